iou_seq_ctrl: RTL
=================

Name: iou_seq_ctrl

Overview:
- Hardware bus master that drives the IOU's IO bus in place of the CPU.
- It queues words from a producer and prints each one to the 7-segment display using the seg_rdy/seg_data polling handshake.
- On request, it fetches one switch-entered word using the swx_vld/swx_data polling handshake.
- Output jobs and input jobs share the single IO bus under round-robin arbitration.

Parameters:
- DEPTH, 4: output FIFO depth in words; must be a power of 2 and at least 2.
- POLL_GAP, 16: idle cycles between consecutive status polls; 0 means polls run back-to-back.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- out_valid  in  1  producer has a word to display
- out_data  in  32  word to display
- out_ready  out  1  FIFO not full; a push occurs when out_valid & out_ready
- in_req  in  1  pulse requesting one switch-entered word
- in_pend  out  1  input request latched and not yet completed
- in_valid  out  1  one-cycle pulse: in_data is updated
- in_data  out  32  last word fetched from swx_data
- busy  out  1  FSM is not in IDLE, or FIFO non-empty, or in_pend
- io_addr  out  8  IO bus address
- io_dout  out  32  IO bus write data
- io_we  out  1  IO bus write strobe
- io_rd  out  1  IO bus read strobe
- io_din  in  32  IO bus read data; combinational from io_addr in the same cycle

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
  - During reset, all outputs are 0 except out_ready, which is 1.
  - FIFO is emptied, in_pend cleared, FSM forced to IDLE, gap counter cleared, last_srv set to IN.
- Reset mid-transaction abandons the transaction; bus strobes drop immediately because reset is asynchronous.
- Bus idle value: io_addr=0x00, io_dout=0, io_we=0, io_rd=0. Strobes and address are registered FSM outputs, asserted for exactly one cycle per access.
- FIFO:
  - Synchronous, DEPTH entries, with a count register of width clog2(DEPTH)+1.
  - Push and pop in the same cycle are allowed whenever not full; count is then unchanged.
  - When full, out_ready=0 and out_valid is ignored.
  - Pops happen only in WRITE_SEG.
- in_req: sets in_pend when in_pend=0. It is ignored while in_pend=1, including during the transaction.
- Arbitration, in IDLE only:
  - If FIFO non-empty and in_pend=1, serve the class opposite to last_srv.
  - Otherwise serve whichever class has work.
  - last_srv updates when the job completes.
- FSM states:
  - IDLE: chooses the next job as above.
  - POLL_SEG: io_addr=0x08, io_rd=1. If io_din[0]=1 go to WRITE_SEG; else go to GAP_SEG, or back to POLL_SEG when POLL_GAP=0.
  - GAP_SEG: count POLL_GAP cycles, then POLL_SEG.
  - WRITE_SEG: io_addr=0x0C, io_dout=FIFO head, io_we=1. Pop the FIFO, set last_srv=OUT, go to IDLE.
  - POLL_SW: io_addr=0x10, io_rd=1. If io_din[0]=1 go to READ_SW; else GAP_SW, or POLL_SW when POLL_GAP=0.
  - GAP_SW: same as GAP_SEG, returning to POLL_SW.
  - READ_SW: io_addr=0x14, io_rd=1. Capture io_din into in_data, go to DONE_SW.
  - DONE_SW: in_valid=1 for this one cycle; clear in_pend, set last_srv=IN, go to IDLE.
- Job commitment: once POLL_SEG or POLL_SW is entered, the job is not preempted. Polling continues indefinitely until the status bit is seen; there is no timeout.
- Minimum latency:
  - FIFO push to io_we, with an idle bus and seg_rdy=1: 3 cycles (push edge → IDLE decides → POLL_SEG → WRITE_SEG).
  - in_req to in_valid, with swx_vld=1: 4 cycles after in_pend sets.
- in_data holds its value until the next READ_SW.
- Status sampling: status bits are sampled only in POLL states. A write to 0x0C drops seg_rdy at the next edge, so back-to-back prints always see seg_rdy=0 on their first poll.

Decomposition:
- Shared package iou_pkg:
  - IO address constants: ADDR_LED=0x00, ADDR_SWT=0x04, ADDR_SEG_RDY=0x08, ADDR_SEG_DATA=0x0C, ADDR_SWX_VLD=0x10, ADDR_SWX_DATA=0x14, ADDR_CNT=0x18.
  - FSM state enum.
  - Class encoding for last_srv (OUT/IN).
- One sub-module: sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. The FSM and arbitration stay in iou_seq_ctrl.

Test Plan:
- Basic print: reset; IOU model with seg_rdy=1; push 0x12345678 → one io_we at addr 0x0C with io_dout=0x12345678 exactly 3 cycles after the push; FIFO empty; busy=0 afterwards.
- Polling and gap: seg_rdy held 0 for 50 cycles, POLL_GAP=16 → 0x08 reads exactly 17 cycles apart with no io_we. Raise seg_rdy → write follows the next poll.
- FIFO full: hold seg_rdy=0 and push 5 words with DEPTH=4 → out_ready=0 after the 4th push and the 5th is rejected. Release seg_rdy per word → writes 0x0C in push order with no loss.
- Input fetch: pulse in_req; swx_vld=1 with swx_data=0x0000ABCD → reads at 0x10 then 0x14, in_valid pulses once with in_data=0x0000ABCD, in_pend clears. A second in_req pulsed while in_pend=1 is ignored.
- Arbitration: FIFO holds 2 words, in_pend=1, all statuses ready → job order is OUT, IN, OUT after reset.
- Mid-reset: assert rstn=0 during GAP_SEG with 3 words queued → io_rd/io_we drop immediately. After release: count=0, out_ready=1, no bus activity.

Source files
------------

// File: rtl/iou_pkg.sv
// Shared IOU definitions: IO bus address map, sequencer FSM states, service classes.
package iou_pkg;

  localparam logic [7:0] ADDR_LED      = 8'h00;
  localparam logic [7:0] ADDR_SWT      = 8'h04;
  localparam logic [7:0] ADDR_SEG_RDY  = 8'h08;
  localparam logic [7:0] ADDR_SEG_DATA = 8'h0C;
  localparam logic [7:0] ADDR_SWX_VLD  = 8'h10;
  localparam logic [7:0] ADDR_SWX_DATA = 8'h14;
  localparam logic [7:0] ADDR_CNT      = 8'h18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_SEG,
    ST_GAP_SEG,
    ST_WRITE_SEG,
    ST_POLL_SW,
    ST_GAP_SW,
    ST_READ_SW,
    ST_DONE_SW
  } state_e;

  typedef enum logic {
    SRV_OUT = 1'b0,
    SRV_IN  = 1'b1
  } srv_e;

endpackage

// File: rtl/iou_seq_ctrl_if.sv
// IOU IO bus: the sequencer drives address/strobes, the IOU returns read data combinationally.
interface iou_seq_ctrl_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;

  modport master (output io_addr, io_dout, io_we, io_rd, input io_din);
  modport slave  (input io_addr, io_dout, io_we, io_rd, output io_din);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of 2 so pointers wrap freely.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/iou_seq_ctrl.sv
// IO bus master standing in for the CPU: prints queued words to the 7-seg display and
// fetches switch-entered words, round-robin between the two job classes.
module iou_seq_ctrl import iou_pkg::*; #(
  parameter int DEPTH    = 4,
  parameter int POLL_GAP = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          out_valid,
  input  logic [31:0]   out_data,
  output logic          out_ready,
  input  logic          in_req,
  output logic          in_pend,
  output logic          in_valid,
  output logic [31:0]   in_data,
  output logic          busy,
  iou_seq_ctrl_if.master io
);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e              state_q, state_d;
  srv_e                last_q, last_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                in_pend_q, in_pend_d;
  logic [31:0]         in_data_q, in_data_d;
  logic                in_valid_q, in_valid_d;
  logic [7:0]          addr_q, addr_d;
  logic [31:0]         dout_q, dout_d;
  logic                we_q, we_d, rd_q, rd_d;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [31:0]         fifo_head;
  logic [$clog2(DEPTH):0] fifo_cnt;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (out_valid),
    .pop   (fifo_pop),
    .din   (out_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gap_d    = gap_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // both classes waiting: alternate against whoever was served last
        if (!fifo_empty && in_pend_q)
          state_d = (last_q == SRV_OUT) ? ST_POLL_SW : ST_POLL_SEG;
        else if (!fifo_empty) state_d = ST_POLL_SEG;
        else if (in_pend_q)   state_d = ST_POLL_SW;
      end
      ST_POLL_SEG: begin
        if (io.io_din[0])       state_d = ST_WRITE_SEG;
        else if (POLL_GAP == 0) state_d = ST_POLL_SEG;
        else begin
          state_d = ST_GAP_SEG;
          gap_d   = '0;
        end
      end
      ST_GAP_SEG: begin
        if (gap_q == GW'(POLL_GAP - 1)) state_d = ST_POLL_SEG;
        else                            gap_d   = gap_q + GW'(1);
      end
      ST_WRITE_SEG: begin
        fifo_pop = 1'b1;
        last_d   = SRV_OUT;
        state_d  = ST_IDLE;
      end
      ST_POLL_SW: begin
        if (io.io_din[0])       state_d = ST_READ_SW;
        else if (POLL_GAP == 0) state_d = ST_POLL_SW;
        else begin
          state_d = ST_GAP_SW;
          gap_d   = '0;
        end
      end
      ST_GAP_SW: begin
        if (gap_q == GW'(POLL_GAP - 1)) state_d = ST_POLL_SW;
        else                            gap_d   = gap_q + GW'(1);
      end
      ST_READ_SW: state_d = ST_DONE_SW;
      ST_DONE_SW: begin
        last_d  = SRV_IN;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bus outputs are decoded from the next state so they are clean flops aligned with the state
  always_comb begin
    addr_d     = ADDR_LED;
    dout_d     = '0;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    in_valid_d = (state_d == ST_DONE_SW);
    case (state_d)
      ST_POLL_SEG:  begin addr_d = ADDR_SEG_RDY;  rd_d = 1'b1; end
      ST_WRITE_SEG: begin addr_d = ADDR_SEG_DATA; we_d = 1'b1; dout_d = fifo_head; end
      ST_POLL_SW:   begin addr_d = ADDR_SWX_VLD;  rd_d = 1'b1; end
      ST_READ_SW:   begin addr_d = ADDR_SWX_DATA; rd_d = 1'b1; end
      default: ;
    endcase
    in_pend_d = in_pend_q ? (state_q != ST_DONE_SW) : in_req;
    in_data_d = (state_q == ST_READ_SW) ? io.io_din : in_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      last_q     <= SRV_IN;
      gap_q      <= '0;
      in_pend_q  <= 1'b0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      in_pend_q  <= in_pend_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
    end
  end

  assign out_ready  = ~fifo_full;
  assign in_pend    = in_pend_q;
  assign in_valid   = in_valid_q;
  assign in_data    = in_data_q;
  assign busy       = (state_q != ST_IDLE) | (fifo_cnt != '0) | in_pend_q;
  assign io.io_addr = addr_q;
  assign io.io_dout = dout_q;
  assign io.io_we   = we_q;
  assign io.io_rd   = rd_q;
endmodule
